uart_rx: RTL and testbench

- 8N1 asynchronous serial receiver. It is the consumer stage on the far end of the UART transmitter's line.
- Samples the serial input on an external oversampling tick, then recovers start, data and stop bits.
- Presents each received byte on a valid/ready output handshake.
- Flags framing errors and overruns as single-cycle pulses.

---
 rtl/uart_rx.sv | 113 +++++++++++
 tb/tb_uart_rx.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver; oversampled start/data/stop recovery with a valid/ready byte output
// and single-cycle framing-error / overrun pulses.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_e;
  localparam logic [CNT_W-1:0] MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLE - 1);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d, data_q, data_d;
  logic [1:0]       sync_q, sync_d;
  logic             valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic             rx_s, done;
  assign rx_s   = sync_q[1];
  assign sync_d = {sync_q[0], rx};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done    = 1'b0;
    ferr_d  = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
        START: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == MID) begin
            state_d = rx_s ? IDLE : DATA;
            cnt_d   = '0;
            bit_d   = '0;
          end
        end
        DATA: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            shift_d = {rx_s, shift_q[7:1]};
            cnt_d   = '0;
            bit_d   = bit_q + 1'b1;
            state_d = (bit_q == 3'd7) ? STOP : DATA;
          end
        end
        STOP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            done    = rx_s;
            ferr_d  = !rx_s;
            state_d = rx_s ? IDLE : BRK;
          end
        end
        BRK: state_d = rx_s ? IDLE : BRK;
        default: state_d = IDLE;
      endcase
    end
  end
  // A completing byte either replaces a consumed/empty slot or is dropped as an overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (done) begin
      data_d  = (!valid_q || ready) ? shift_q : data_q;
      valid_d = 1'b1;
      ovr_d   = valid_q && !ready;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      sync_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      sync_q  <= sync_d;
    end
  end
  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames; expected bytes queued at send time, popped by a
// monitor on each valid/ready handshake.
module tb_uart_rx;
  localparam int OS = 16;
  logic       clk = 1'b0, rst_n = 1'b0, tick = 1'b0, rx = 1'b1, ready = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, overrun;
  int         passed = 0, total = 0, div = 1, tcnt = 0;
  int         n_ferr = 0, n_ovr = 0, exp_ferr = 0, exp_ovr = 0;
  logic       prev_ferr = 1'b0, prev_ovr = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx #(.OVERSAMPLE(OS), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx), .data(data), .valid(valid),
    .ready(ready), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    tick = (tcnt == 0);
    tcnt = (tcnt + 1 >= div) ? 0 : tcnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Line-level decode: data bits sit between the start bit and the stop bit, LSB first.
  function automatic logic [7:0] model(input logic [9:0] line);
    logic [7:0] r = 8'h00;
    for (int i = 1; i <= 8; i++) r = r + (8'(line[i]) << (i - 1));
    return r;
  endfunction

  task automatic hold(input logic lvl, input int nticks);
    rx = lvl;
    repeat (nticks * div) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int stop_ticks, input logic stop_lvl, input bit push);
    logic [9:0] line;
    line = {stop_lvl, b, 1'b0};
    if (push && line[9]) exp_q.push_back(model(line));
    for (int i = 0; i < 9; i++) hold(line[i], OS);
    hold(line[9], stop_ticks);
  endtask

  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL sb_unexpected: got byte %0h, expected none", data);
        end else chk("sb_data", 32'(data), 32'(exp_q.pop_front()));
      end
      if (frame_err) begin
        n_ferr++;
        chk("ferr_width", 32'(prev_ferr), 0);
      end
      if (overrun) begin
        n_ovr++;
        chk("ovr_width", 32'(prev_ovr), 0);
      end
      prev_ferr = frame_err;
      prev_ovr  = overrun;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [7:0] b;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(data), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    chk("rst_ovr", 32'(overrun), 0);
    rst_n = 1'b1;
    hold(1, 2 * OS);
    // A5 with tick every clk: sync (2) + detecting tick (1) + OS/2 + 9*OS
    fork
      send(8'hA5, OS, 1, 1);
      begin
        lat = 0;
        while (!valid && lat < 400) begin
          @(posedge clk);
          #1;
          lat++;
        end
        chk("a5_latency", lat, OS / 2 + 9 * OS + 3);
        @(posedge clk);
        #1;
        chk("a5_pulse", 32'(valid), 0);
      end
    join
    hold(1, 2 * OS);
    chk("a5_no_ferr", n_ferr, 0);
    hold(0, 4);
    hold(1, 2 * OS);
    send(8'h3C, OS, 1, 1);
    hold(1, 2 * OS);
    send(8'hFF, 40 * OS, 0, 0);
    exp_ferr++;
    hold(1, 2 * OS);
    chk("brk_one_ferr", n_ferr, exp_ferr);
    send(8'h81, OS, 1, 1);
    hold(1, 2 * OS);
    ready = 1'b0;
    send(8'h11, OS, 1, 1);
    send(8'h22, OS, 1, 0);
    exp_ovr++;
    hold(1, 2 * OS);
    chk("ovr_hold_data", 32'(data), 32'h11);
    chk("ovr_hold_valid", 32'(valid), 1);
    chk("ovr_count", n_ovr, exp_ovr);
    ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ovr_release", 32'(valid), 0);
    @(negedge clk);
    div = 4;
    for (int i = 0; i < 16; i++) send(8'(i), 12, 1, 1);
    hold(1, 2 * OS);
    div = 1;
    ready = 1'b0;
    send(8'h77, OS, 1, 0);
    hold(1, OS);
    chk("pre_rst_valid", 32'(valid), 1);
    b = 8'hC3;
    hold(0, OS);
    for (int i = 0; i < 3; i++) hold(b[i], OS);
    hold(b[3], OS / 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_data", 32'(data), 0);
    chk("midrst_valid", 32'(valid), 0);
    chk("midrst_ferr", 32'(frame_err), 0);
    chk("midrst_ovr", 32'(overrun), 0);
    rx = 1'b1;
    ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(1, 2 * OS);
    send(8'h5A, OS, 1, 1);
    hold(1, 2 * OS);
    for (int k = 0; k < 8; k++) begin
      div = $urandom_range(1, 3);
      send(8'($urandom_range(0, 255)), $urandom_range(12, 16), 1, 1);
    end
    div = 1;
    hold(1, 2 * OS);
    chk("sb_empty", exp_q.size(), 0);
    chk("ferr_total", n_ferr, exp_ferr);
    chk("ovr_total", n_ovr, exp_ovr);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
